// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types, segment patterns and helpers for rtc_display_ctrl.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the top.
package rtc_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_ALM_H,
    SET_ALM_M
  } state_e;

  localparam int KEY_MODE = 0;
  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 2;
  localparam int KEY_ALM  = 3;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Binary 0..63 to {tens,units} via fixed compare/subtract steps.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 6'd40) begin
      r = r - 6'd40;
      t = 4'd4;
    end
    if (r >= 6'd20) begin
      r = r - 6'd20;
      t = t + 4'd2;
    end
    if (r >= 6'd10) begin
      r = r - 6'd10;
      t = t + 4'd1;
    end
    return {t, r[3:0]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF sync, stable-level debounce and one-cycle press pulse.
// Ports: clk, rst_n (sync, active-low), key_n (raw, active-low), press (out).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    s1_d    = key_n;
    s2_d    = s1_q;
    lvl_d   = lvl_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d   = s2_q;
        press_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/rtc_display_ctrl.sv
// rtc_display_ctrl: HH:MM:SS clock, set/alarm FSM, keys and 6-digit display.
// Ports: clk, rst_n, key_n[3:0], hex0..hex5[6:0], led[3:0], tick_1hz.
module rtc_display_ctrl
  import rtc_pkg::*;
#(
  parameter int TICK_CYCLES     = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int MODE_24H        = 1,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [3:0] led,
  output logic       tick_1hz
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [6:0] POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] RST_0 = SEG_0 ^ POL;
  localparam logic [6:0] RST_H5 = ((MODE_24H != 0) ? SEG_0 : SEG_1) ^ POL;
  localparam logic [6:0] RST_H4 = ((MODE_24H != 0) ? SEG_0 : SEG_2) ^ POL;

  logic [3:0] press;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk  (clk),
      .rst_n(rst_n),
      .key_n(key_n[gi]),
      .press(press[gi])
    );
  end

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    hour_q, hour_d, alm_h_q, alm_h_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d, alm_m_q, alm_m_d;
  logic          alm_en_q, alm_en_d, ring_q, ring_d;
  logic          tick_d_q, tick_d_d;
  logic [BW-1:0] bl_cnt_q, bl_cnt_d;
  logic          bl_ph_q, bl_ph_d;
  logic [6:0]    hex_q [6];
  logic [6:0]    hex_d [6];
  logic [3:0]    led_q, led_d;

  logic       run_pre, tick, up, dn;
  state_e     nxt;
  logic [4:0] dh, h12, hsel;
  logic [5:0] dm;
  logic [7:0] hb, mb, sb;
  logic       pm, show_alm, blank_h, blank_m;

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    alm_h_d  = alm_h_q;
    alm_m_d  = alm_m_q;
    alm_en_d = alm_en_q;
    ring_d   = ring_q;
    run_pre  = state_q inside {RUN, SET_ALM_H, SET_ALM_M};
    tick     = run_pre && (pre_q == PW'(TICK_CYCLES - 1));
    tick_d_d = tick;
    up       = press[KEY_UP] & ~press[KEY_DOWN];
    dn       = press[KEY_DOWN] & ~press[KEY_UP];
    pre_d    = (!run_pre || tick) ? '0 : pre_q + 1'b1;

    unique case (state_q)
      RUN:       nxt = SET_HOUR;
      SET_HOUR:  nxt = SET_MIN;
      SET_MIN:   nxt = SET_ALM_H;
      SET_ALM_H: nxt = SET_ALM_M;
      default:   nxt = RUN;
    endcase

    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // A press while ringing only silences the alarm.
    if (ring_q && (|press)) begin
      ring_d = 1'b0;
    end else begin
      if (press[KEY_MODE]) begin
        state_d = nxt;
        if (nxt == SET_HOUR) sec_d = '0;
      end
      if (press[KEY_ALM]) begin
        alm_en_d = ~alm_en_q;
        if (alm_en_q) ring_d = 1'b0;
      end
      unique case (1'b1)
        (state_q == SET_HOUR) && up:
          hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
        (state_q == SET_HOUR) && dn:
          hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
        (state_q == SET_MIN) && up:
          min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
        (state_q == SET_MIN) && dn:
          min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        (state_q == SET_ALM_H) && up:
          alm_h_d = (alm_h_q == 5'd23) ? '0 : alm_h_q + 5'd1;
        (state_q == SET_ALM_H) && dn:
          alm_h_d = (alm_h_q == 5'd0) ? 5'd23 : alm_h_q - 5'd1;
        (state_q == SET_ALM_M) && up:
          alm_m_d = (alm_m_q == 6'd59) ? '0 : alm_m_q + 6'd1;
        (state_q == SET_ALM_M) && dn:
          alm_m_d = (alm_m_q == 6'd0) ? 6'd59 : alm_m_q - 6'd1;
        default: ;
      endcase
    end

    if ((state_q == RUN) && alm_en_d && tick_d_q && (sec_q == 6'd0)
        && (hour_q == alm_h_q) && (min_q == alm_m_q)) begin
      ring_d = 1'b1;
    end

    // Blink phase restarts on every state change.
    if (state_d != state_q) begin
      bl_cnt_d = '0;
      bl_ph_d  = 1'b0;
    end else if (bl_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      bl_cnt_d = '0;
      bl_ph_d  = ~bl_ph_q;
    end else begin
      bl_cnt_d = bl_cnt_q + 1'b1;
      bl_ph_d  = bl_ph_q;
    end
  end

  always_comb begin
    show_alm = state_q inside {SET_ALM_H, SET_ALM_M};
    dh       = show_alm ? alm_h_q : hour_q;
    dm       = show_alm ? alm_m_q : min_q;
    pm       = (dh >= 5'd12);
    if (dh == 5'd0)       h12 = 5'd12;
    else if (dh > 5'd12)  h12 = dh - 5'd12;
    else                  h12 = dh;
    hsel     = (MODE_24H != 0) ? dh : h12;
    hb       = bin2bcd({1'b0, hsel});
    mb       = bin2bcd(dm);
    sb       = bin2bcd(sec_q);
    blank_h  = bl_ph_q && (state_q inside {SET_HOUR, SET_ALM_H});
    blank_m  = bl_ph_q && (state_q inside {SET_MIN, SET_ALM_M});
    hex_d[0] = (show_alm ? SEG_BLANK : seg_decode(sb[3:0])) ^ POL;
    hex_d[1] = (show_alm ? SEG_BLANK : seg_decode(sb[7:4])) ^ POL;
    hex_d[2] = (blank_m ? SEG_BLANK : seg_decode(mb[3:0])) ^ POL;
    hex_d[3] = (blank_m ? SEG_BLANK : seg_decode(mb[7:4])) ^ POL;
    hex_d[4] = (blank_h ? SEG_BLANK : seg_decode(hb[3:0])) ^ POL;
    hex_d[5] = (blank_h ? SEG_BLANK : seg_decode(hb[7:4])) ^ POL;
    led_d    = {(MODE_24H == 0) && pm, state_q != RUN, ring_q, alm_en_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pre_q    <= '0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      alm_h_q  <= '0;
      alm_m_q  <= '0;
      alm_en_q <= 1'b0;
      ring_q   <= 1'b0;
      tick_d_q <= 1'b0;
      bl_cnt_q <= '0;
      bl_ph_q  <= 1'b0;
      hex_q[0] <= RST_0;
      hex_q[1] <= RST_0;
      hex_q[2] <= RST_0;
      hex_q[3] <= RST_0;
      hex_q[4] <= RST_H4;
      hex_q[5] <= RST_H5;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      alm_h_q  <= alm_h_d;
      alm_m_q  <= alm_m_d;
      alm_en_q <= alm_en_d;
      ring_q   <= ring_d;
      tick_d_q <= tick_d_d;
      bl_cnt_q <= bl_cnt_d;
      bl_ph_q  <= bl_ph_d;
      hex_q    <= hex_d;
      led_q    <= led_d;
    end
  end

  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];
  assign led      = led_q;
  assign tick_1hz = tick;

endmodule

// File: tb/tb_rtc_display_ctrl.sv
// tb_rtc_display_ctrl: directed test of rtc_display_ctrl in 24h and 12h builds.
// Small sim parameters: tick every 4, debounce 3, blink half-period 2.
module tb_rtc_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [6:0] h0, h1, h2, h3, h4, h5;
  logic [6:0] g0, g1, g2, g3, g4, g5;
  logic [3:0] led, led12;
  logic       tick, tick12;
  int         total = 0;
  int         bad = 0;

  localparam logic [6:0] BLK = 7'h7F;

  rtc_display_ctrl #(
    .TICK_CYCLES(4), .DEBOUNCE_CYCLES(3), .BLINK_CYCLES(2),
    .MODE_24H(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .hex4(h4), .hex5(h5),
    .led(led), .tick_1hz(tick)
  );

  rtc_display_ctrl #(
    .TICK_CYCLES(4), .DEBOUNCE_CYCLES(3), .BLINK_CYCLES(2),
    .MODE_24H(0), .SEG_ACTIVE_LOW(1)
  ) dut12 (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .hex0(g0), .hex1(g1), .hex2(g2), .hex3(g3), .hex4(g4), .hex5(g5),
    .led(led12), .tick_1hz(tick12)
  );

  always #5 clk = ~clk;

  // Active-low board patterns written out per digit.
  function automatic logic [6:0] sg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLK;
    endcase
  endfunction

  function automatic logic [13:0] pair(input int v);
    return {sg(v / 10), sg(v % 10)};
  endfunction

  function automatic logic [41:0] tv(input int h, input int m, input int s);
    return {pair(h), pair(m), pair(s)};
  endfunction

  function automatic logic [41:0] got24();
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pk(input int k);
    @(negedge clk);
    key_n[k] = 1'b0;
    repeat (8) @(negedge clk);
    key_n[k] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pkn(input int k, input int n);
    repeat (n) pk(k);
  endtask

  task automatic wait_time(input string tag, input int h, input int m,
                           input int s, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (got24() == tv(h, m, s)) break;
    end
    chk(tag, got24(), tv(h, m, s));
  endtask

  initial begin
    int n, cnt, first, nb, tk, bad_oth;
    logic [13:0] hv;
    logic [27:0] lo;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hex24", got24(), tv(0, 0, 0));
    chk("rst_hex12", {g5, g4, g3, g2, g1, g0}, tv(12, 0, 0));
    chk("rst_led", led, 4'h0);
    chk("rst_tick", tick, 1'b0);

    // glitch on UP: no press
    @(negedge clk);
    key_n[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    key_n[1] = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      cnt += int'(dut.press[1]);
    end
    chk("glitch", cnt, 0);

    // held UP: one press, 5 cycles after the edge
    @(negedge clk);
    key_n[1] = 1'b0;
    cnt = 0;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (dut.press[1]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    key_n[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(dut.press[1]);
    end
    chk("press_lat", first, 5);
    chk("press_once", cnt, 1);

    // tick period
    n = 0;
    while (!tick && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", tick, 1'b1);
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tick && n < 20);
      chk("tick_per", n, 4);
    end

    // SET_HOUR, DOWN at 00 -> 23
    pk(0);
    chk("led_set", led[2], 1'b1);
    pk(2);
    nb = 0; tk = 0; bad_oth = 0; hv = '0;
    lo = {pair(0), pair(0)};
    repeat (8) begin
      @(negedge clk);
      if (h5 == BLK && h4 == BLK) nb++;
      else hv = {h5, h4};
      tk += int'(tick);
      if ({h3, h2, h1, h0} != lo) bad_oth++;
    end
    chk("blink_h", nb, 4);
    chk("hour_23", hv, pair(23));
    chk("frozen", tk, 0);
    chk("min_sec", bad_oth, 0);

    // SET_MIN: DOWN 0->59, UP 59->00, DOWN again
    pk(0);
    pk(2);
    nb = 0; bad_oth = 0; hv = '0;
    repeat (8) begin
      @(negedge clk);
      if (h3 == BLK && h2 == BLK) nb++;
      else hv = {h3, h2};
      if ({h5, h4} != pair(23)) bad_oth++;
    end
    chk("blink_m", nb, 4);
    chk("min_59", hv, pair(59));
    chk("hr_keep", bad_oth, 0);
    pk(1);
    n = 0;
    while (h3 == BLK && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("min_00", {h5, h4, h3, h2}, {pair(23), pair(0)});
    pk(2);

    // alarm view: sec blank, alarm minutes 00
    pk(0);
    chk("alm_view", {h3, h2, h1, h0}, {pair(0), BLK, BLK});
    pk(0);
    pk(0);
    chk("led_run", led[2], 1'b0);

    wait_time("t235959", 23, 59, 59, 400);
    chk("h12_23", {g5, g4, led12[3]}, {pair(11), 1'b1});
    wait_time("t000000", 0, 0, 0, 8);
    chk("h12_00", {g5, g4, led12[3]}, {pair(12), 1'b0});

    // set 12:34 and run to 12:34:56
    pk(0);
    pkn(1, 12);
    pk(0);
    pkn(1, 34);
    pkn(0, 3);
    wait_time("t123456", 12, 34, 56, 400);
    chk("h12_12", {g5, g4, led12[3]}, {pair(12), 1'b1});
    chk("pm24", led[3], 1'b0);

    // hour 13
    pk(0);
    pk(1);
    pkn(0, 4);
    chk("h24_13", {h5, h4}, pair(13));
    chk("h12_13", {g5, g4, led12[3]}, {pair(1), 1'b1});

    // alarm 00:01 enabled, time 00:00
    pk(0);
    pkn(1, 11);
    pk(0);
    pkn(1, 26);
    pk(0);
    pk(0);
    pk(1);
    pk(3);
    chk("alm_en", led[0], 1'b1);
    pk(0);
    wait_time("t000058", 0, 0, 58, 400);
    chk("no_ring", led[1], 1'b0);
    wait_time("t000100", 0, 1, 0, 12);
    n = 0;
    while (!led[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ring", led[1], 1'b1);
    repeat (12) @(negedge clk);
    chk("ring_hold", led[1], 1'b1);
    pk(1);
    chk("ring_clr", led[2:0], 3'b001);
    chk("t_keep", {h5, h4, h3, h2}, {pair(0), pair(1)});

    // reset mid-edit
    pk(0);
    pkn(1, 7);
    pk(0);
    chk("edit_07", {h5, h4, led[2]}, {pair(7), 1'b1});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rr_hex", got24(), tv(0, 0, 0));
    chk("rr_led", led, 4'h0);
    repeat (2) @(negedge clk);
    chk("rr_run", {got24(), led}, {tv(0, 0, 0), 4'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
